// File: rtl/hdmi_period_scheduler.sv
// ---------------------------------------------------------------------------
// hdmi_period_scheduler
//
// Purpose:
//   Sits between the video timing generator and the three TMDS channel
//   encoders. Raw timing (de/hsync/vsync) and pixels are delayed by a fixed
//   lookahead so that, ahead of every active line that follows a long enough
//   blanking gap, an HDMI video preamble and a video guard band can be
//   inserted. For each encoder it selects the period type, the two control
//   bits and the 8-bit pixel data.
//
// Ports:
//   clk_i        pixel clock
//   rst_i        asynchronous reset, active-high
//   de_i         data enable from the timing generator
//   hsync_i      horizontal sync
//   vsync_i      vertical sync
//   rgb_i        pixel {R[23:16], G[15:8], B[7:0]}
//   data_type_o  period per channel, [0]=blue [1]=green [2]=red
//   c0_o         control bit c0 per channel
//   c1_o         control bit c1 per channel
//   data_o       8-bit data per channel, [0]=B [1]=G [2]=R
//   gap_err_o    one-cycle pulse: a line start was too close to the previous
//                line to carry a preamble and goes out as plain video
// ---------------------------------------------------------------------------

package hdmi_period_pkg;

  typedef enum logic [1:0] {
    CONTROL_PERIOD = 2'd0,
    VIDEO_PERIOD   = 2'd1,
    DATA_PERIOD    = 2'd2,
    AUDIO_PERIOD   = 2'd3
  } tmds_period_e;

  typedef logic [7:0] tmds_data_t;

endpackage

module hdmi_period_scheduler
  import hdmi_period_pkg::*;
#(
  parameter int HDMI_MODE    = 1,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  de_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  input  logic [23:0]           rgb_i,
  output tmds_period_e [2:0]    data_type_o,
  output logic [2:0]            c0_o,
  output logic [2:0]            c1_o,
  output tmds_data_t [2:0]      data_o,
  output logic                  gap_err_o
);

  localparam int LATENCY = PREAMBLE_LEN + GUARD_LEN + 1;
  // The output register supplies the last cycle of latency.
  localparam int DLY     = LATENCY - 1;
  localparam int GAP     = PREAMBLE_LEN + GUARD_LEN;
  localparam int LOW_W   = $clog2(GAP + 1);
  localparam int MAXLEN  = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
  localparam int CNT_W   = $clog2(MAXLEN + 1);
  localparam bit HDMI_EN = (HDMI_MODE != 0);

  localparam logic [LOW_W-1:0] GAP_MIN  = LOW_W'(GAP);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_LEN - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRE   = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  typedef struct packed {
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [23:0] rgb;
  } sample_t;

  sample_t            pipe_q [DLY];
  sample_t            tail;

  logic               dePrev_q;
  logic [LOW_W-1:0]   lowCnt_q, lowCnt_d;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               risingEdge;
  logic               gapOk;
  logic               accept;
  logic               gapErr_d;

  tmds_period_e [2:0] dataType_q, dataType_d;
  logic [2:0]         c0_q, c0_d;
  logic [2:0]         c1_q, c1_d;
  tmds_data_t [2:0]   data_q, data_d;
  logic               gapErr_q;

  assign tail = pipe_q[DLY-1];

  // Line-start detection. Any rising edge inside the preamble/guard window
  // necessarily sees a short gap, so it is rejected by the gap test alone.
  assign risingEdge = de_i & ~dePrev_q;
  assign gapOk      = (lowCnt_q >= GAP_MIN);
  assign accept     = HDMI_EN & risingEdge & gapOk;
  assign gapErr_d   = HDMI_EN & risingEdge & ~gapOk;

  // Blanking-gap length, saturating once it is long enough for a preamble.
  always_comb begin
    lowCnt_d = lowCnt_q;
    if (de_i) begin
      lowCnt_d = '0;
    end else if (lowCnt_q != GAP_MIN) begin
      lowCnt_d = lowCnt_q + 1'b1;
    end
  end

  // Preamble/guard sequencer, started by an accepted line start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_PRE;
          cnt_d   = '0;
        end
      end
      ST_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == GRD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output selection. The mux looks at the state being entered so the
  // preamble appears on the cycle right after the accepted line start.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dataType_d[i] = CONTROL_PERIOD;
    end
    c0_d   = 3'b000;
    c1_d   = 3'b000;
    data_d = '0;
    if (tail.de) begin
      for (int i = 0; i < 3; i++) begin
        dataType_d[i] = VIDEO_PERIOD;
      end
      data_d[0] = tail.rgb[7:0];
      data_d[1] = tail.rgb[15:8];
      data_d[2] = tail.rgb[23:16];
    end else if (state_d == ST_PRE) begin
      c0_d = {1'b0, 1'b1, tail.hsync};
      c1_d = {1'b0, 1'b0, tail.vsync};
    end else if (state_d == ST_GUARD) begin
      dataType_d[0] = AUDIO_PERIOD;
      dataType_d[1] = DATA_PERIOD;
      dataType_d[2] = AUDIO_PERIOD;
    end else begin
      c0_d = {2'b00, tail.hsync};
      c1_d = {2'b00, tail.vsync};
    end
  end

  // Delay line and control state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DLY; i++) begin
        pipe_q[i] <= '0;
      end
      dePrev_q <= 1'b0;
      lowCnt_q <= GAP_MIN;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
    end else begin
      pipe_q[0] <= '{de: de_i, hsync: hsync_i, vsync: vsync_i, rgb: rgb_i};
      for (int i = 1; i < DLY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      dePrev_q <= de_i;
      lowCnt_q <= lowCnt_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  // Registered encoder controls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 3; i++) begin
        dataType_q[i] <= CONTROL_PERIOD;
      end
      c0_q     <= 3'b000;
      c1_q     <= 3'b000;
      data_q   <= '0;
      gapErr_q <= 1'b0;
    end else begin
      dataType_q <= dataType_d;
      c0_q       <= c0_d;
      c1_q       <= c1_d;
      data_q     <= data_d;
      gapErr_q   <= gapErr_d;
    end
  end

  assign data_type_o = dataType_q;
  assign c0_o        = c0_q;
  assign c1_o        = c1_q;
  assign data_o      = data_q;
  assign gap_err_o   = gapErr_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hdmi_period_scheduler
//
// Drives one HDMI-mode and one DVI-mode scheduler from the same timing
// stream. Expected outputs come from a reference model that works directly
// on the recorded input history: it finds accepted line starts by looking
// back over the blanking gap and places preamble/guard windows by cycle
// arithmetic relative to those starts.
// ---------------------------------------------------------------------------

module tb_hdmi_period_scheduler;
  import hdmi_period_pkg::*;

  localparam int P     = 8;
  localparam int G     = 2;
  localparam int LAT   = P + G + 1;
  localparam int DEPTH = 8192;

  logic               clk = 1'b0;
  logic               rst;
  logic               de;
  logic               hs;
  logic               vs;
  logic [23:0]        rgb;

  tmds_period_e [2:0] dtH, dtD;
  logic [2:0]         c0H, c1H, c0D, c1D;
  tmds_data_t [2:0]   dataH, dataD;
  logic               errH, errD;

  int                 errors = 0;
  int                 checks = 0;
  int                 cyc = 0;
  int                 epochStart = 0;
  bit                 inReset = 1'b0;
  int                 errSeenH;
  int                 errSeenD;

  bit                 deHist [DEPTH];
  bit                 hsHist [DEPTH];
  bit                 vsHist [DEPTH];
  logic [23:0]        rgbHist [DEPTH];

  typedef struct {
    int gap;
    int len;
    int hsStart;
    bit expErr;
  } row_t;

  row_t rows [8];

  hdmi_period_scheduler #(.HDMI_MODE(1), .PREAMBLE_LEN(P), .GUARD_LEN(G)) dutHdmi (
    .clk_i(clk), .rst_i(rst), .de_i(de), .hsync_i(hs), .vsync_i(vs), .rgb_i(rgb),
    .data_type_o(dtH), .c0_o(c0H), .c1_o(c1H), .data_o(dataH), .gap_err_o(errH)
  );

  hdmi_period_scheduler #(.HDMI_MODE(0), .PREAMBLE_LEN(P), .GUARD_LEN(G)) dutDvi (
    .clk_i(clk), .rst_i(rst), .de_i(de), .hsync_i(hs), .vsync_i(vs), .rgb_i(rgb),
    .data_type_o(dtD), .c0_o(c0D), .c1_o(c1D), .data_o(dataD), .gap_err_o(errD)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: actual=still running required=finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Line start at cycle t (after reset release).
  function automatic bit isRise(int t);
    if (t < epochStart) return 1'b0;
    if (!deHist[t]) return 1'b0;
    if (t == epochStart) return 1'b1;
    return !deHist[t-1];
  endfunction

  // Blanking cycles before t, capped at P+G; reset counts as a full gap.
  function automatic int lowBefore(int t);
    int n = 0;
    int j = t - 1;
    while (n < P + G) begin
      if (j < epochStart) return P + G;
      if (deHist[j]) return n;
      n++;
      j--;
    end
    return n;
  endfunction

  function automatic bit accepted(int t, bit hdmi);
    return hdmi && isRise(t) && (lowBefore(t) >= P + G);
  endfunction

  function automatic bit rejected(int t, bit hdmi);
    return hdmi && isRise(t) && (lowBefore(t) < P + G);
  endfunction

  // Expected {data_type[2:0], c0, c1, data[2:0], gap_err} visible after edge k.
  function automatic logic [36:0] model(int k, bit hdmi);
    logic [1:0]  t0, t1, t2;
    logic [2:0]  c0, c1;
    logic [23:0] d;
    bit          sd, sh, sv;
    logic [23:0] sp;
    int          s;
    int          phase;
    if (inReset) return '0;
    s = k - (LAT - 1);
    if (s >= epochStart) begin
      sd = deHist[s]; sh = hsHist[s]; sv = vsHist[s]; sp = rgbHist[s];
    end else begin
      sd = 1'b0; sh = 1'b0; sv = 1'b0; sp = '0;
    end
    phase = 0;
    for (int t = k - (P + G) + 1; t <= k; t++) begin
      if (t >= epochStart && accepted(t, hdmi)) phase = (k + 1 - t <= P) ? 1 : 2;
    end
    t0 = CONTROL_PERIOD; t1 = CONTROL_PERIOD; t2 = CONTROL_PERIOD;
    c0 = 3'b000; c1 = 3'b000; d = '0;
    if (sd) begin
      t0 = VIDEO_PERIOD; t1 = VIDEO_PERIOD; t2 = VIDEO_PERIOD;
      d  = sp;
    end else if (phase == 1) begin
      c0 = {2'b01, sh};
      c1 = {2'b00, sv};
    end else if (phase == 2) begin
      t0 = AUDIO_PERIOD; t1 = DATA_PERIOD; t2 = AUDIO_PERIOD;
    end else begin
      c0 = {2'b00, sh};
      c1 = {2'b00, sv};
    end
    return {t2, t1, t0, c0, c1, d, rejected(k, hdmi)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit d, input bit h, input bit v, input logic [23:0] p);
    if (cyc >= DEPTH) begin
      $display("[TB] FAIL history: actual=%0d required<%0d", cyc, DEPTH);
      $fatal(1, "[TB] history overflow");
    end
    deHist[cyc] = d; hsHist[cyc] = h; vsHist[cyc] = v; rgbHist[cyc] = p;
    de = d; hs = h; vs = v; rgb = p;
    @(posedge clk);
    #1;
    checkOutput($sformatf("hdmi.out@%0d", cyc), 64'({dtH, c0H, c1H, dataH, errH}),
                64'(model(cyc, 1'b1)));
    checkOutput($sformatf("dvi.out@%0d", cyc), 64'({dtD, c0D, c1D, dataD, errD}),
                64'(model(cyc, 1'b0)));
    errSeenH += int'(errH);
    errSeenD += int'(errD);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    rows[0] = '{gap: 40, len: 16, hsStart: 35, expErr: 1'b0};
    rows[1] = '{gap: 10, len: 5,  hsStart: -1, expErr: 1'b0};
    rows[2] = '{gap: 9,  len: 5,  hsStart: 2,  expErr: 1'b1};
    rows[3] = '{gap: 3,  len: 4,  hsStart: -1, expErr: 1'b1};
    rows[4] = '{gap: 11, len: 1,  hsStart: 6,  expErr: 1'b0};
    rows[5] = '{gap: 1,  len: 3,  hsStart: -1, expErr: 1'b1};
    rows[6] = '{gap: 10, len: 2,  hsStart: 7,  expErr: 1'b0};
    rows[7] = '{gap: 2,  len: 6,  hsStart: -1, expErr: 1'b1};

    rst = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; rgb = '0;
    inReset = 1'b1;
    errSeenH = 0; errSeenD = 0;
    idle(3);
    rst = 1'b0;
    inReset = 1'b0;
    epochStart = cyc;

    // Directed lines: gap lengths around the preamble threshold.
    for (int r = 0; r < 8; r++) begin
      errSeenH = 0;
      errSeenD = 0;
      for (int i = 0; i < rows[r].gap; i++) begin
        bit h;
        h = (rows[r].hsStart >= 0) && (i >= rows[r].hsStart) && (i < rows[r].hsStart + 3);
        applyStimulus(1'b0, h, (r == 4), 24'h0);
      end
      for (int i = 0; i < rows[r].len; i++) applyStimulus(1'b1, 1'b0, 1'b0, 24'($urandom));
      checkOutput($sformatf("row%0d.hdmiGapErr", r), 64'(errSeenH > 0), 64'(rows[r].expErr));
      checkOutput($sformatf("row%0d.dviGapErr", r), 64'(errSeenD), 64'(0));
    end
    idle(LAT + 4);

    // Reset during the preamble of a line, de held high across release.
    idle(40);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 24'hA5A5A5);
    rst = 1'b1;
    #1;
    checkOutput("midReset.hdmi", 64'({dtH, c0H, c1H, dataH, errH}), 64'(0));
    checkOutput("midReset.dvi", 64'({dtD, c0D, c1D, dataD, errD}), 64'(0));
    inReset = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 24'h111111);
    rst = 1'b0;
    inReset = 1'b0;
    epochStart = cyc;
    errSeenH = 0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 24'(i * 24'h010203));
    checkOutput("afterReset.gapErr", 64'(errSeenH), 64'(0));
    idle(LAT + 4);

    // Random lines, gaps and sync activity.
    for (int l = 0; l < 60; l++) begin
      int gap;
      int len;
      gap = $urandom_range(1, 16);
      len = $urandom_range(1, 20);
      for (int i = 0; i < gap; i++) begin
        applyStimulus(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 24'h0);
      end
      for (int i = 0; i < len; i++) applyStimulus(1'b1, 1'b0, 1'b0, 24'($urandom));
    end
    idle(LAT + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
